// File: rtl/rv32i_types.sv
// rv32i_types: shared word type, responder FSM states and byte-mask constant
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [2:0] {IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B} mem_port_state_t;
  localparam logic [3:0] MEM_WMASK_ALL = 4'hF;
endpackage

// File: rtl/mem_port_responder_if.sv
// mem_port_responder_if: requester ports A/B plus the physical memory side
interface mem_port_responder_if;
  import rv32i_types::*;
  logic read_a;
  rv32i_word address_a;
  logic resp_a;
  rv32i_word rdata_a;
  logic read_b;
  logic write_b;
  rv32i_word address_b;
  rv32i_word wdata_b;
  logic [3:0] wmask_b;
  logic resp_b;
  rv32i_word rdata_b;
  logic pmem_read;
  logic pmem_write;
  rv32i_word pmem_address;
  rv32i_word pmem_wdata;
  logic [3:0] pmem_wmask;
  rv32i_word pmem_rdata;
  logic pmem_resp;
  modport slave (
    input read_a, address_a, read_b, write_b, address_b, wdata_b, wmask_b, pmem_rdata, pmem_resp,
    output resp_a, rdata_a, resp_b, rdata_b, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
  );
  modport master (
    output read_a, address_a, read_b, write_b, address_b, wdata_b, wmask_b, pmem_rdata, pmem_resp,
    input resp_a, rdata_a, resp_b, rdata_b, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
  );
endinterface

// File: rtl/mem_port_fetch_buf.sv
// mem_port_fetch_buf: one-entry fetch buffer with tag compare (MEM_PORT_FETCH_BUF_EN)
`ifdef MEM_PORT_FETCH_BUF_EN
module mem_port_fetch_buf
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [31:2] fill_tag,
  input  rv32i_word   fill_data,
  input  logic        inval,
  input  logic [31:2] inval_tag,
  input  logic [31:2] lookup_tag,
  output logic        hit,
  output rv32i_word   data
);
  logic valid;
  logic [31:2] tag;
  assign hit = valid && lookup_tag == tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag <= '0;
      data <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag <= fill_tag;
      data <= fill_data;
    end else if (inval && inval_tag == tag) begin
      valid <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/mem_port_responder.sv
// mem_port_responder: arbitrates fetch port A and data port B onto one pmem port, B first
// Optional one-entry fetch buffer enabled by defining MEM_PORT_FETCH_BUF_EN.
module mem_port_responder
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int WM_W = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_responder_if.slave bus,
  output logic err_timeout
);
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  mem_port_state_t state, nxt;
  rv32i_word addr_q, wdata_q, buf_data;
  logic [WM_W-1:0] mask_q;
  logic [CW-1:0] wait_q;
  logic wr_q, err_q, hit;
  logic req_b, busy;
  assign req_b = bus.read_b | bus.write_b;
  assign busy = state == BUSY_A || state == BUSY_B;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.pmem_wmask = mask_q;
  assign err_timeout = err_q | (busy && TIMEOUT_CYCLES != 0 && int'(wait_q) >= TIMEOUT_CYCLES - 1);
`ifdef MEM_PORT_FETCH_BUF_EN
  mem_port_fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .fill       (state == BUSY_A && bus.pmem_resp),
    .fill_tag   (addr_q[31:2]),
    .fill_data  (bus.pmem_rdata),
    .inval      (state == IDLE && bus.write_b),
    .inval_tag  (bus.address_b[31:2]),
    .lookup_tag (bus.address_a[31:2]),
    .hit        (hit),
    .data       (buf_data)
  );
`else
  assign hit = 1'b0;
  assign buf_data = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    bus.resp_a = state == RESP_A;
    bus.resp_b = state == RESP_B;
    bus.pmem_read = state == BUSY_A || (state == BUSY_B && !wr_q);
    bus.pmem_write = state == BUSY_B && wr_q;
    unique case (state)
      IDLE:    nxt = req_b ? BUSY_B : !bus.read_a ? IDLE : hit ? RESP_A : BUSY_A;
      BUSY_A:  nxt = bus.pmem_resp ? RESP_A : BUSY_A;
      BUSY_B:  nxt = bus.pmem_resp ? RESP_B : BUSY_B;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
      wr_q <= 1'b0;
      wait_q <= '0;
      err_q <= 1'b0;
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
    end else begin
      if (state == IDLE && req_b) begin
        addr_q <= bus.address_b;
        wdata_q <= bus.wdata_b;
        mask_q <= bus.wmask_b;
        wr_q <= bus.write_b;
      end else if (state == IDLE && bus.read_a) begin
        addr_q <= bus.address_a;
        wr_q <= 1'b0;
      end
      wait_q <= !busy ? '0 : &wait_q ? wait_q : wait_q + 1'b1;
      err_q <= err_timeout;
      if (state == BUSY_A && bus.pmem_resp) bus.rdata_a <= bus.pmem_rdata;
      else if (state == IDLE && nxt == RESP_A) bus.rdata_a <= buf_data;
      if (state == BUSY_B && bus.pmem_resp && !wr_q) bus.rdata_b <= bus.pmem_rdata;
    end
  end
endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Responder end of the fetch and data memory request protocol.
- Serves port A (instruction fetch, read-only) and port B (data, read/write) using level-held requests and one-cycle response pulses.
- Arbitrates both ports onto a single physical memory interface (pmem) with variable latency.
- Sits between the pipeline stages and the memory model or cache.

Parameters:
- TIMEOUT_CYCLES, 255: pmem wait cycles before err_timeout is set; 0 disables the watchdog.
- WM_W, 4: byte-mask width (32-bit word / 8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- read_a  in  1  fetch read request, level-held until resp_a
- address_a  in  32  fetch address
- resp_a  out  1  fetch response pulse
- rdata_a  out  32  fetch data, valid when resp_a=1
- read_b  in  1  data read request
- write_b  in  1  data write request
- address_b  in  32  data address
- wdata_b  in  32  write data
- wmask_b  in  4  byte enables
- resp_b  out  1  data response pulse (read or write)
- rdata_b  out  32  read data, valid when resp_b=1
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_address  out  32  physical address
- pmem_wdata  out  32  physical write data
- pmem_wmask  out  4  physical byte enables
- pmem_rdata  in  32  physical read data
- pmem_resp  in  1  physical completion
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B.
- IDLE:
  - read_b|write_b → latch address_b, wdata_b, wmask_b and the op; go to BUSY_B.
  - Otherwise read_a → latch address_a; go to BUSY_A.
  - Port B has strict priority over port A.
- BUSY_x:
  - pmem_read=1 (A, or B read) or pmem_write=1 (B write).
  - pmem_address, pmem_wdata, pmem_wmask driven from latched registers only. Requester inputs changing mid-transaction have no effect.
  - Wait counter increments each cycle.
  - On pmem_resp=1: capture pmem_rdata into rdata_x (reads only; rdata_b holds its previous value on writes), then go to RESP_x.
- RESP_x:
  - resp_x=1 for exactly one cycle, then IDLE.
  - Requests are not sampled in RESP, so the requester has one edge to update its address.
- Minimum latency: request sampled in cycle 0, pmem_resp in cycle 1 → resp_x in cycle 2.
- In-flight A transaction: completes even if read_a drops or read_b rises. A pending B is served on the next IDLE.
- read_b and write_b both high: treated as a write.
- Only one of pmem_read or pmem_write is ever high, and only in BUSY.
- resp_a and resp_b are never both high.
- Watchdog:
  - Counter is 8 bits minimum and saturates.
  - When it reaches TIMEOUT_CYCLES in BUSY, err_timeout is set and stays set until rst.
  - The transaction is not aborted.
  - Counter clears on entry to BUSY.
- Reset (any state, including mid-BUSY):
  - Next state is IDLE.
  - All strobes, resp_a, resp_b and err_timeout = 0.
  - rdata_a, rdata_b and latched registers = 0.
  - pmem_resp arriving after reset is ignored.

Optional Feature:
- Macro: MEM_PORT_FETCH_BUF_EN.
- Defined:
  - Adds a one-entry fetch buffer {valid, tag[31:2], data}, filled on every BUSY_A completion.
  - In IDLE with no B request, read_a with address_a[31:2]==tag and valid → load data into rdata_a and go straight to RESP_A. pmem is not accessed; latency is 1 cycle.
  - A B write whose address[31:2] matches the tag clears valid at BUSY_B entry.
  - rst clears valid.
- Undefined: no buffer; every fetch goes to pmem.

Decomposition:
- rv32i_types package gets:
  - enum mem_port_state_t (the five states).
  - Constant MEM_WMASK_ALL = 4'hF.
- rv32i_word is used for all 32-bit buses.
- One sub-module, mem_port_fetch_buf: the buffer storage plus hit compare, instantiated only under the macro.

Test Plan:
- Single fetch: read_a=1, address_a=0x60, pmem returns 0x00A00093 after 3 cycles → pmem_read held 3 cycles, resp_a one cycle with rdata_a=0x00A00093, resp_b=0.
- Collision: read_a and read_b rise together, address_b=0x100 → B served first (pmem_address=0x100, resp_b), then A served on the next IDLE.
- Write: write_b=1, address_b=0x200, wdata_b=0xDEADBEEF, wmask_b=4'b0011 → pmem_write=1 with the same values, resp_b pulse, rdata_b unchanged.
- Watchdog: TIMEOUT_CYCLES=4, pmem_resp withheld 10 cycles → err_timeout=1 from the 4th BUSY cycle; resp still delivered on pmem_resp; err_timeout stays 1 until rst.
- Reset mid-BUSY_A: rst asserted in the second BUSY cycle, pmem_resp arrives one cycle after rst → no resp_a, IDLE, all outputs 0.
- MEM_PORT_FETCH_BUF_EN: fetch 0x60 twice → second resp_a one cycle after sampling with no pmem_read. Then write_b to 0x60 and fetch 0x60 again → pmem_read issued.
